// File: rtl/uart_word_assembler.sv
// Packs UART bytes into 16-bit words tagged with their frame index, keeps a
// running word checksum, and flags frame completion, half-word timeouts and overrun bytes.
module uart_word_assembler #(
    parameter int unsigned WORDS          = 64,
    parameter int unsigned MSB_FIRST      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        clr,
    input  logic        byte_dv,
    input  logic [7:0]  byte_in,
    output logic        word_dv,
    output logic [15:0] word,
    output logic [5:0]  word_idx,
    output logic        frame_done,
    output logic [15:0] checksum,
    output logic        timeout_err,
    output logic        extra_err
);

    localparam int unsigned IDX_W = 6;
    localparam int unsigned TMR_W = 16;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         hold, hold_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [IDX_W-1:0]   wcnt, wcnt_nxt;
    logic               word_dv_nxt;
    logic [15:0]        word_nxt;
    logic [IDX_W-1:0]   word_idx_nxt;
    logic               frame_done_nxt;
    logic [15:0]        checksum_nxt;
    logic               timeout_err_nxt;
    logic               extra_err_nxt;
    logic [15:0]        pair_c;

    // Combine the held first byte with the incoming second byte.
    always_comb begin
        pair_c = (MSB_FIRST != 0) ? {hold, byte_in} : {byte_in, hold};
    end

    // Next-state and next-output logic; clr overrides any byte in the same cycle.
    always_comb begin
        state_nxt       = state;
        hold_nxt        = hold;
        tmr_nxt         = tmr;
        wcnt_nxt        = wcnt;
        word_dv_nxt     = 1'b0;
        word_nxt        = word;
        word_idx_nxt    = word_idx;
        frame_done_nxt  = frame_done;
        checksum_nxt    = checksum;
        timeout_err_nxt = timeout_err;
        extra_err_nxt   = extra_err;

        if (clr) begin
            state_nxt       = IDLE;
            wcnt_nxt        = '0;
            checksum_nxt    = '0;
            frame_done_nxt  = 1'b0;
            timeout_err_nxt = 1'b0;
            extra_err_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_dv) begin
                        hold_nxt  = byte_in;
                        tmr_nxt   = '0;
                        state_nxt = HALF;
                    end
                end
                HALF: begin
                    if (byte_dv) begin
                        word_nxt     = pair_c;
                        word_idx_nxt = wcnt;
                        word_dv_nxt  = 1'b1;
                        checksum_nxt = checksum + pair_c;
                        wcnt_nxt     = wcnt + IDX_W'(1);
                        if (wcnt == LAST_WORD) begin
                            state_nxt      = DONE;
                            frame_done_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (tmr == TMR_LAST) begin
                        // Second byte never arrived: drop the stale half-word.
                        hold_nxt        = '0;
                        timeout_err_nxt = 1'b1;
                        state_nxt       = IDLE;
                    end else begin
                        tmr_nxt = tmr + TMR_W'(1);
                    end
                end
                DONE: begin
                    if (byte_dv) begin
                        extra_err_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and output registers, advanced only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold        <= '0;
            tmr         <= '0;
            wcnt        <= '0;
            word_dv     <= 1'b0;
            word        <= '0;
            word_idx    <= '0;
            frame_done  <= 1'b0;
            checksum    <= '0;
            timeout_err <= 1'b0;
            extra_err   <= 1'b0;
        end else if (ce) begin
            state       <= state_nxt;
            hold        <= hold_nxt;
            tmr         <= tmr_nxt;
            wcnt        <= wcnt_nxt;
            word_dv     <= word_dv_nxt;
            word        <= word_nxt;
            word_idx    <= word_idx_nxt;
            frame_done  <= frame_done_nxt;
            checksum    <= checksum_nxt;
            timeout_err <= timeout_err_nxt;
            extra_err   <= extra_err_nxt;
        end
    end

endmodule
